// File: rtl/reg_rw_pkg.sv
// Shared defaults and types for the reg_rw control/status register file.
// Optional feature macro used by reg_rw: REG_RW_RD_VALID_EN.
package reg_rw_pkg;

  localparam int unsigned DATA_W_DEF = 32'd8;
  localparam int unsigned ADDR_W_DEF = 32'd3;
  localparam int unsigned DEPTH_DEF  = 32'd8;
  localparam logic [DATA_W_DEF-1:0] RST_VAL_DEF = 8'h00;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/reg_rw.sv
// Register file: DEPTH x DATA_W flops, shared write/read address, registered read.
// Define REG_RW_RD_VALID_EN to add o_rd_valid, a registered copy of i_rd_en.
module reg_rw
  import reg_rw_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(RST_VAL_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
`ifdef REG_RW_RD_VALID_EN
  output logic              o_rd_valid,
`endif
  output logic [DATA_W-1:0] o_Data
);

  logic [DATA_W-1:0] regs_s [DEPTH];
  logic [DEPTH-1:0]  wr_sel_s;
  logic [DATA_W-1:0] rd_mux_s;
  logic              hit_s;
  logic [DATA_W-1:0] rd_data_s;

  // Per-register write decode and storage; an X address never matches a known index.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    logic [DATA_W-1:0] q_r;

    assign wr_sel_s[g] = i_wr_en && (i_wrAddr == ADDR_W'(g));

    // Storage flop for register g.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        q_r <= RST_VAL;
      end else if (wr_sel_s[g]) begin
        q_r <= i_wrData;
      end else begin
        q_r <= q_r;
      end
    end

    assign regs_s[g] = q_r;
  end

  // Read mux; hit_s flags an implemented address so out-of-range reads return RST_VAL.
  always_comb begin
    rd_mux_s = RST_VAL;
    hit_s    = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_mux_s = (i_wrAddr == ADDR_W'(i)) ? regs_s[i] : rd_mux_s;
      hit_s    = (i_wrAddr == ADDR_W'(i)) ? 1'b1      : hit_s;
    end
  end

  // Write-first: a same-cycle write to the read address bypasses the register.
  always_comb begin
    rd_data_s = RST_VAL;
    if (!hit_s) begin
      rd_data_s = RST_VAL;
    end else if (i_wr_en) begin
      rd_data_s = i_wrData;
    end else begin
      rd_data_s = rd_mux_s;
    end
  end

  // Read data register; holds its value when no read is issued.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_Data <= RST_VAL;
    end else if (i_rd_en) begin
      o_Data <= rd_data_s;
    end else begin
      o_Data <= o_Data;
    end
  end

`ifdef REG_RW_RD_VALID_EN
  // Marks the cycles in which o_Data was loaded by a read, including out-of-range reads.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
    end
  end
`endif

endmodule

// File: tb/tb_reg_rw.sv
// Directed self-checking bench for reg_rw (default 8 x 8-bit build).
// Also exercises o_rd_valid when REG_RW_RD_VALID_EN is defined.
module tb_reg_rw;

  logic       i_clk;
  logic       i_rstn;
  logic       i_wr_en;
  logic       i_rd_en;
  logic [2:0] i_wrAddr;
  logic [7:0] i_wrData;
  logic [7:0] o_Data;
`ifdef REG_RW_RD_VALID_EN
  logic       o_rd_valid;
`endif

  int checks = 0;
  int errors = 0;

  reg_rw dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_wr_en  (i_wr_en),
    .i_rd_en  (i_rd_en),
    .i_wrAddr (i_wrAddr),
    .i_wrData (i_wrData),
`ifdef REG_RW_RD_VALID_EN
    .o_rd_valid (o_rd_valid),
`endif
    .o_Data   (o_Data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic wr, input logic rd, input logic [2:0] addr, input logic [7:0] data);
    @(negedge i_clk);
    i_wr_en  = wr;
    i_rd_en  = rd;
    i_wrAddr = addr;
    i_wrData = data;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_valid(input string tag, input logic exp);
`ifdef REG_RW_RD_VALID_EN
    chk(tag, {31'd0, o_rd_valid}, {31'd0, exp});
`endif
  endtask

  initial begin
    i_rstn   = 1'b0;
    i_wr_en  = 1'b1;
    i_rd_en  = 1'b1;
    i_wrAddr = 3'd0;
    i_wrData = 8'd100;
    repeat (3) @(posedge i_clk);
    #1;

    // Reset held with enables active: everything stays at RST_VAL.
    chk("rst_o_data", {24'd0, o_Data}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      chk($sformatf("rst_reg%0d", a), {24'd0, dut.regs_s[a]}, 32'd0);
    end
    chk_valid("rst_valid", 1'b0);

    @(negedge i_clk);
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    i_rstn  = 1'b1;

    for (int a = 0; a < 8; a++) begin
      step(1'b0, 1'b1, 3'(a), 8'd0);
      chk($sformatf("post_rst_rd%0d", a), {24'd0, o_Data}, 32'd0);
    end
    chk_valid("valid_after_read", 1'b1);

    // Write then read back; o_Data must not move on a write-only cycle.
    step(1'b1, 1'b0, 3'd0, 8'd100);
    chk("wr_only_hold", {24'd0, o_Data}, 32'd0);
    chk_valid("valid_no_read", 1'b0);
    step(1'b0, 1'b1, 3'd0, 8'd0);
    chk("rd_addr0", {24'd0, o_Data}, 32'd100);

    // Hold: no read, address changes, o_Data keeps 100.
    step(1'b0, 1'b0, 3'd3, 8'd0);
    chk("hold1", {24'd0, o_Data}, 32'd100);
    step(1'b0, 1'b0, 3'd1, 8'd0);
    chk("hold2", {24'd0, o_Data}, 32'd100);
    step(1'b0, 1'b1, 3'd1, 8'd0);
    chk("rd_addr1", {24'd0, o_Data}, 32'd0);

    // Walk: distinct value per address, read back in reverse.
    for (int a = 0; a < 8; a++) begin
      step(1'b1, 1'b0, 3'(a), 8'(10 + a));
    end
    for (int a = 7; a >= 0; a--) begin
      step(1'b0, 1'b1, 3'(a), 8'd0);
      chk($sformatf("walk_rd%0d", a), {24'd0, o_Data}, 32'(10 + a));
    end

    // Write-first on a simultaneous write and read of the same address.
    step(1'b1, 1'b0, 3'd2, 8'h11);
    step(1'b1, 1'b1, 3'd2, 8'h5A);
    chk("wr_first", {24'd0, o_Data}, 32'h5A);
    step(1'b0, 1'b1, 3'd2, 8'd0);
    chk("wr_first_stored", {24'd0, o_Data}, 32'h5A);
    step(1'b0, 1'b1, 3'd3, 8'd0);
    chk("neighbour_intact", {24'd0, o_Data}, 32'd13);
    chk_valid("valid_before_rst", 1'b1);

    // Reset asserted between edges during a write to addr 4.
    @(negedge i_clk);
    i_wr_en  = 1'b1;
    i_rd_en  = 1'b1;
    i_wrAddr = 3'd4;
    i_wrData = 8'h77;
    #2;
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_o_data", {24'd0, o_Data}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      chk($sformatf("mid_rst_reg%0d", a), {24'd0, dut.regs_s[a]}, 32'd0);
    end
    chk_valid("mid_rst_valid", 1'b0);
    @(posedge i_clk);
    #1;
    chk("rst_beats_write", {24'd0, dut.regs_s[4]}, 32'd0);

    @(negedge i_clk);
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    i_rstn  = 1'b1;
    step(1'b0, 1'b1, 3'd4, 8'd0);
    chk("post_mid_rst_rd4", {24'd0, o_Data}, 32'd0);
    step(1'b0, 1'b1, 3'd7, 8'd0);
    chk("post_mid_rst_rd7", {24'd0, o_Data}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_rw.md
Name: reg_rw

Overview:
- Small control/status register file: DEPTH words of DATA_W bits, one shared address for write and read.
- Synchronous writes, registered read output.
- Sits behind a simple register bus, for example an APB slave bridge. It provides the storage for configuration registers.
- Default build: 8 x 8-bit registers, 3-bit address.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width.
- DEPTH, 8, number of implemented registers; must be ≤ 2**ADDR_W.
- RST_VAL, 0, reset value of every register and of o_Data.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rstn  input  1  reset, asynchronous, active-low. One clock; reset asserts asynchronously and is active-low.
- i_wr_en  input  1  write enable, sampled on the rising edge of i_clk.
- i_rd_en  input  1  read enable, sampled on the rising edge of i_clk.
- i_wrAddr  input  ADDR_W  register address, used for both write and read.
- i_wrData  input  DATA_W  write data.
- o_Data  output  DATA_W  registered read data.

Behaviour:
- Reset (i_rstn=0):
  - Immediately, without a clock edge, every register becomes RST_VAL and o_Data becomes RST_VAL.
  - Writes and reads are ignored while reset is held.
  - Reset asserted in the middle of operation wins over any concurrent write or read.
- Write: at a rising edge with i_rstn=1 and i_wr_en=1, reg[i_wrAddr] <= i_wrData.
  - Only the addressed register changes.
  - Write data is visible to a read issued at the next edge.
- Read: at a rising edge with i_rstn=1 and i_rd_en=1, o_Data <= value of reg[i_wrAddr].
  - Latency is 1 cycle: o_Data is valid after the edge that sampled i_rd_en.
- No read (i_rd_en=0): o_Data holds its last value. It does not go to zero and does not track the address.
- Simultaneous i_wr_en=1 and i_rd_en=1 to the same address: write-first. o_Data <= i_wrData in that same edge, and the register is also updated.
- Simultaneous write and read to different addresses: both complete independently in the same cycle.
- Out-of-range address (i_wrAddr ≥ DEPTH, possible only when DEPTH < 2**ADDR_W):
  - A write is discarded.
  - A read loads RST_VAL into o_Data.
- Unknown (X) address or enable: no requirement on register contents. The implementation must not corrupt unaddressed registers when the address is known.
- No handshake, no back-pressure; one access per cycle.
- Pure register storage: no side-effect registers (no W1C, no read-clear).

Optional Feature:
- Macro: REG_RW_RD_VALID_EN.
- With the macro defined, an extra port is present: o_rd_valid  output  1.
  - o_rd_valid is a registered copy of i_rd_en. It is high for exactly the cycle(s) in which o_Data was loaded by a read.
  - It resets to 0 asynchronously with i_rstn.
  - An out-of-range read still asserts o_rd_valid.
- Without the macro: the port and its flop do not exist; all other behaviour is identical.

Decomposition:
- Package reg_rw_pkg holds:
  - localparams for the default DATA_W, ADDR_W, DEPTH and RST_VAL;
  - a typedef for the data word;
  - a typedef for the address.
- No sub-module is needed. The storage is a flop array inside reg_rw: a generate loop with per-register write decode, plus one read mux feeding the o_Data flop.

Test Plan:
- Reset: hold i_rstn=0 with enables high and i_wrData=100 → all 8 registers and o_Data = 0. Release reset, read each address 0..7 → o_Data = 0 each time.
- Write/read: write 100 to addr 0, then read addr 0 → o_Data = 100 one cycle after the read edge. Read addr 1 → 0.
- Walk: write value 10+a to addr a for a = 0..7, then read back in reverse order → each o_Data = 10+a. No aliasing between addresses.
- Hold: after reading 100 from addr 0, drop i_rd_en and change the address to 3 → o_Data stays 100 until the next read.
- Write-first: i_wr_en=1, i_rd_en=1, addr 2, data 0x5A, register previously 0x11 → o_Data = 0x5A after that edge. A later read of addr 2 → 0x5A.
- Reset mid-operation: regs loaded; assert i_rstn low between clock edges during a write to addr 4 → o_Data and all regs return to 0 immediately. After release, addr 4 reads 0. With REG_RW_RD_VALID_EN, o_rd_valid drops to 0 at the same instant.
